coin_acceptor: RTL and testbench

Front-end coin acceptor that drives the coin input of the vending controller. It synchronises and debounces the raw coin-chute sensor and measures the sensor pulse width to classify each coin as 5 rs or 10 rs. It then emits a single-cycle coin code on the same 2-bit encoding the controller consumes (01 = 5 rs, 10 = 10 rs). Invalid, inhibited or stuck events raise a reject pulse instead.

---
 rtl/coin_pkg.sv | 23 ++
 rtl/coin_debounce.sv | 44 ++++
 rtl/coin_acceptor.sv | 188 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor FSM state encoding; the codes are also
// consumed by the vending controller.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_EMIT    = 3'd2,
    ST_STUCK   = 3'd3,
    ST_GAP     = 3'd4
  } acc_state_e;

  function automatic logic in_window(input logic [31:0] val,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Sensor synchroniser followed by a stability filter: the filtered level
// follows the synced level only after DEBOUNCE_CYC consecutive agreeing cycles.
module coin_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic filtered
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1'b1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DB_W-1:0]        stable_cnt_r;
  logic                   filt_r;
  logic                   synced_s;

  assign synced_s = sync_r[SYNC_STAGES-1];
  assign filtered = filt_r;

  // Synchroniser shift and run-length count of disagreement with the filtered level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r       <= {SYNC_STAGES{1'b0}};
      stable_cnt_r <= {DB_W{1'b0}};
      filt_r       <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sensor};
      if (synced_s == filt_r) begin
        stable_cnt_r <= {DB_W{1'b0}};
      end else if (stable_cnt_r == DB_LAST) begin
        filt_r       <= synced_s;
        stable_cnt_r <= {DB_W{1'b0}};
      end else begin
        stable_cnt_r <= stable_cnt_r + DB_ONE;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced sensor pulse width classified into a 5/10 rs code
// or a reject pulse. Optional accepted-coin tallies under COIN_ACC_TALLY_EN.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned W5_MIN       = 20,
  parameter int unsigned W5_MAX       = 40,
  parameter int unsigned W10_MIN      = 50,
  parameter int unsigned W10_MAX      = 80,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GAP_CYC      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor,
  input  logic        inhibit,
  output logic [1:0]  coin,
  output logic        reject,
  output logic        busy
`ifdef COIN_ACC_TALLY_EN
  ,
  output logic [15:0] cnt5,
  output logic [15:0] cnt10
`endif
);

  localparam logic [CNT_W-1:0] W_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] W_SAT    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] W_SAT_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam int unsigned      GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);

  acc_state_e       state_r, state_n;
  logic [CNT_W-1:0] width_r, width_n;
  logic [GAP_W-1:0] gap_r, gap_n;
  logic             inh_r, inh_n;
  logic             filt_s, filt_d_r, rise_s, fall_s;
  logic [1:0]       coin_r, coin_n, code_s;
  logic             reject_r, reject_n, code_rej_s;
  logic             busy_r;
  logic [31:0]      width_ext_s;

  coin_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .sensor  (sensor),
    .filtered(filt_s)
  );

  assign rise_s      = filt_s & ~filt_d_r;
  assign fall_s      = filt_d_r & ~filt_s;
  assign width_ext_s = 32'(width_r);

  // Classification of the finished pulse; inhibit in the falling-edge cycle counts
  always_comb begin
    code_s     = COIN_NONE;
    code_rej_s = 1'b1;
    if (inh_r || inhibit) begin
      code_s     = COIN_NONE;
      code_rej_s = 1'b1;
    end else if (in_window(width_ext_s, W5_MIN, W5_MAX)) begin
      code_s     = COIN_5;
      code_rej_s = 1'b0;
    end else if (in_window(width_ext_s, W10_MIN, W10_MAX)) begin
      code_s     = COIN_10;
      code_rej_s = 1'b0;
    end else begin
      code_s     = COIN_NONE;
      code_rej_s = 1'b1;
    end
  end

  // Next-state, measurement bookkeeping and next output values
  always_comb begin
    state_n  = state_r;
    width_n  = width_r;
    inh_n    = inh_r;
    gap_n    = gap_r;
    coin_n   = COIN_NONE;
    reject_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_n = ST_MEASURE;
          width_n = W_ONE;
          inh_n   = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        inh_n = inh_r | inhibit;
        if (fall_s) begin
          state_n  = ST_EMIT;
          coin_n   = code_s;
          reject_n = code_rej_s;
        end else if (width_r == W_SAT_M1) begin
          width_n  = W_SAT;
          state_n  = ST_STUCK;
          reject_n = 1'b1;
        end else begin
          width_n = width_r + W_ONE;
        end
      end
      ST_EMIT: begin
        state_n = ST_GAP;
        gap_n   = {GAP_W{1'b0}};
      end
      ST_STUCK: begin
        if (!filt_s) begin
          state_n = ST_GAP;
          gap_n   = {GAP_W{1'b0}};
        end else begin
          state_n = ST_STUCK;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_n = ST_IDLE;
        end else begin
          gap_n = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state, measurement registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      width_r  <= {CNT_W{1'b0}};
      inh_r    <= 1'b0;
      gap_r    <= {GAP_W{1'b0}};
      filt_d_r <= 1'b0;
      coin_r   <= COIN_NONE;
      reject_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      width_r  <= width_n;
      inh_r    <= inh_n;
      gap_r    <= gap_n;
      filt_d_r <= filt_s;
      coin_r   <= coin_n;
      reject_r <= reject_n;
      busy_r   <= (state_n != ST_IDLE);
    end
  end

  assign coin   = coin_r;
  assign reject = reject_r;
  assign busy   = busy_r;

`ifdef COIN_ACC_TALLY_EN
  logic [15:0] cnt5_r, cnt10_r;

  // Accepted-coin tallies, bumped while the code is on the output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt5_r  <= 16'h0000;
      cnt10_r <= 16'h0000;
    end else if (state_r == ST_EMIT) begin
      if (coin_r == COIN_5) begin
        cnt5_r <= cnt5_r + 16'h0001;
      end else if (coin_r == COIN_10) begin
        cnt10_r <= cnt10_r + 16'h0001;
      end else begin
        cnt5_r <= cnt5_r;
      end
    end else begin
      cnt5_r <= cnt5_r;
    end
  end

  assign cnt5  = cnt5_r;
  assign cnt10 = cnt10_r;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: each pulse pushes its expected event
// (code and output cycle) and a negedge monitor pops and compares.
module tb_coin_acceptor;

  localparam int S     = 2;
  localparam int D     = 4;
  localparam int GAP   = 8;
  localparam int SAT   = 255;
  localparam int W5LO  = 20;
  localparam int W5HI  = 40;
  localparam int W10LO = 50;
  localparam int W10HI = 80;

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor = 1'b0;
  logic       inhibit = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
`ifdef COIN_ACC_TALLY_EN
  logic [15:0] cnt5, cnt10;
`endif

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   idle_at = 0;
  int   exp5 = 0;
  int   exp10 = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  coin_acceptor #(
    .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .W5_MIN(W5LO), .W5_MAX(W5HI),
    .W10_MIN(W10LO), .W10_MAX(W10HI), .CNT_W(8), .GAP_CYC(GAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor),
    .inhibit(inhibit),
    .coin   (coin),
    .reject (reject),
    .busy   (busy)
`ifdef COIN_ACC_TALLY_EN
    ,
    .cnt5   (cnt5),
    .cnt10  (cnt10)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Output monitor: every coin/reject pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset && (coin != 2'b00 || reject)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {29'd0, reject, coin}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_code", {29'd0, reject, coin}, {29'd0, mon_e.code});
        check("evt_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Drive one raw pulse of w cycles; inh_at is the offset of a 1-cycle inhibit (-1: none)
  task automatic drive_pulse(input int w, input int inh_at, output int k);
    exp_t e;
    int   steps;
    logic hit;
    k = cyc;
    if (w >= D && (k + S + D) >= idle_at) begin
      if (w >= SAT) begin
        e.code  = 3'b100;
        e.cyc   = k + S + D + SAT;
        idle_at = k + w + S + D + GAP + 1;
      end else begin
        e.cyc = k + w + S + D + 1;
        hit   = (inh_at >= S + D + 1) && (inh_at <= w + S + D);
        if (hit) begin
          e.code = 3'b100;
        end else if (w >= W5LO && w <= W5HI) begin
          e.code = 3'b001;
          exp5++;
        end else if (w >= W10LO && w <= W10HI) begin
          e.code = 3'b010;
          exp10++;
        end else begin
          e.code = 3'b100;
        end
        idle_at = e.cyc + GAP + 1;
      end
      exp_q.push_back(e);
    end
    steps = (inh_at >= w) ? inh_at + 1 : w;
    for (int i = 0; i < steps; i++) begin
      sensor  = (i < w);
      inhibit = (i == inh_at);
      step();
    end
    sensor  = 1'b0;
    inhibit = 1'b0;
  endtask

  initial begin
    int   k;
    int   k2;
    logic busy_seen;

    #2;
    check("rst_coin", {30'd0, coin}, 32'd0);
    check("rst_reject", {31'd0, reject}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef COIN_ACC_TALLY_EN
    check("rst_cnt5", {16'd0, cnt5}, 32'd0);
    check("rst_cnt10", {16'd0, cnt10}, 32'd0);
`endif
    #20;
    reset = 1'b1;
    repeat (5) step();

    drive_pulse(30, -1, k);
    repeat (30) step();
    drive_pulse(60, -1, k);
    repeat (30) step();
    drive_pulse(45, -1, k);
    repeat (30) step();

    // Glitch shorter than the debounce window, then a good coin
    drive_pulse(3, -1, k);
    busy_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      busy_seen = busy_seen | busy;
      step();
    end
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);
    drive_pulse(30, -1, k);
    repeat (30) step();

    // Lockout: second coin starts two cycles after the first EMIT
    drive_pulse(30, -1, k);
    wait_until(k + 30 + S + D + 1 + 2);
    drive_pulse(30, -1, k2);
    repeat (40) step();

    drive_pulse(30, 15, k);
    repeat (30) step();
    drive_pulse(30, 30 + S + D, k);
    repeat (30) step();

`ifdef COIN_ACC_TALLY_EN
    check("tally_cnt5", {16'd0, cnt5}, 32'(exp5));
    check("tally_cnt10", {16'd0, cnt10}, 32'(exp10));
`endif

    // Stuck sensor: one reject at saturation, busy drops after the gap
    drive_pulse(300, -1, k);
    wait_until(idle_at - 1);
    check("stuck_busy_hi", {31'd0, busy}, 32'd1);
    wait_until(idle_at);
    check("stuck_busy_lo", {31'd0, busy}, 32'd0);
    repeat (10) step();

    // Reset in the middle of a measurement
    sensor = 1'b1;
    repeat (15) step();
    check("meas_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_coin", {30'd0, coin}, 32'd0);
    check("mrst_reject", {31'd0, reject}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
`ifdef COIN_ACC_TALLY_EN
    check("mrst_cnt5", {16'd0, cnt5}, 32'd0);
    check("mrst_cnt10", {16'd0, cnt10}, 32'd0);
`endif
    sensor = 1'b0;
    idle_at = 0;
    repeat (3) step();
    reset = 1'b1;
    repeat (30) step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
